disp_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the alarm clock's 4-digit common-anode seven-segment display. It shares the single BCD-to-segment decoder among all digits by cycling a digit index, presenting the selected BCD nibble and decoder enable, and driving the active-low anode lines. Each slot has a ghosting guard interval, per-digit blanking and per-digit blinking for time/alarm setting. It sits between the timekeeping/setting logic and the seven-segment decoder.

---
 rtl/disp_scan_ctrl_pkg.sv | 17 +
 rtl/disp_scan_ctrl_slot_timer.sv | 37 +++
 rtl/disp_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// rtl/disp_scan_ctrl_pkg.sv - shared types and constants for the display scan controller
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Board clock defaults: 50000-cycle slots, 500 cycles of ghosting guard.
  localparam int DEF_SLOT_CYCLES  = 50000;
  localparam int DEF_GUARD_CYCLES = 500;

  // Common-anode drive: 1 turns a digit off. Sliced to NUM_DIGITS by users.
  localparam logic [31:0] ANODES_OFF = '1;

endpackage

// File: rtl/disp_scan_ctrl_slot_timer.sv
// rtl/disp_scan_ctrl_slot_timer.sv - loadable down-counter timing guard and drive phases
module slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire,
  output logic             expire_soon
);

  logic [CNT_W-1:0] cnt;
  logic             running;

  // Load counts a phase of load_val cycles; expire marks its final cycle.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val - CNT_W'(1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - CNT_W'(1);
    end
  end

  assign expire      = running && (cnt == '0);
  assign expire_soon = running && (cnt == CNT_W'(1));

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - time-multiplexed scan controller for a common-anode 7-seg display
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_N,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_In,
  input  logic [NUM_DIGITS-1:0]   blank_Mask,
  input  logic [NUM_DIGITS-1:0]   blink_Mask,
  input  logic                    blink_Tick,
  output logic [3:0]              bcd_Out,
  output logic                    disp_On_Out,
  output logic [NUM_DIGITS-1:0]   an_Out,
  output logic [IDX_W-1:0]        digit_Idx,
  output logic                    frame_Done
);

  localparam int                    CNT_W     = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      GUARD_LEN = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0]      DRIVE_LEN = CNT_W'(SLOT_CYCLES - GUARD_CYCLES);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = ANODES_OFF[NUM_DIGITS-1:0];

  scan_state_t             state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] snap;
  logic                    vis;
  logic                    phase;
  logic                    tmr_load;
  logic [CNT_W-1:0]        tmr_val;
  logic                    tmr_expire;
  logic                    tmr_expire_soon;
  logic                    guard_entry;
  logic                    last_next;

  slot_timer #(
    .CNT_W (CNT_W)
  ) u_slot_timer (
    .clk         (clk),
    .reset_N     (reset_N),
    .clear       (!enable),
    .load        (tmr_load),
    .load_val    (tmr_val),
    .expire      (tmr_expire),
    .expire_soon (tmr_expire_soon)
  );

  // State and slot index registers.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state, next index and timer reloads; enable low always parks in IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_load  = 1'b0;
    tmr_val   = GUARD_LEN;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = GUARD;
          idx_nxt   = '0;
          tmr_load  = 1'b1;
          tmr_val   = GUARD_LEN;
        end
        GUARD: if (tmr_expire) begin
          state_nxt = DRIVE;
          tmr_load  = 1'b1;
          tmr_val   = DRIVE_LEN;
        end
        DRIVE: if (tmr_expire) begin
          state_nxt = GUARD;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          tmr_load  = 1'b1;
          tmr_val   = GUARD_LEN;
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  assign guard_entry = (state_nxt == GUARD) && (state != GUARD);
  // True when the cycle after this edge is the last one of the current phase.
  assign last_next   = tmr_load ? (tmr_val == CNT_W'(1)) : tmr_expire_soon;
  assign digit_Idx   = idx;

  // Blink phase flips on every tick regardless of scan state.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) phase <= 1'b0;
    else          phase <= phase ^ blink_Tick;
  end

  // Per-slot latch: frame snapshot on digit 0, then digit value and visibility.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      snap    <= '0;
      vis     <= 1'b0;
      bcd_Out <= '0;
    end else if (state_nxt == IDLE) begin
      bcd_Out <= '0;
    end else if (guard_entry) begin
      if (idx_nxt == '0) snap <= digits_In;
      bcd_Out <= (idx_nxt == '0) ? digits_In[3:0] : snap[4*idx_nxt +: 4];
      vis     <= !blank_Mask[idx_nxt] && !(blink_Mask[idx_nxt] && phase);
    end
  end

  // Registered anode, decoder enable and end-of-frame pulse.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      an_Out      <= AN_OFF;
      disp_On_Out <= 1'b0;
      frame_Done  <= 1'b0;
    end else begin
      an_Out      <= AN_OFF;
      disp_On_Out <= 1'b0;
      if ((state_nxt == DRIVE) && vis) begin
        an_Out[idx_nxt] <= 1'b0;
        disp_On_Out     <= 1'b1;
      end
      frame_Done <= (state_nxt == DRIVE) && (idx_nxt == LAST_IDX) && last_next;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - randomized self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        enable;
  logic [15:0] digits_In;
  logic [3:0]  blank_Mask;
  logic [3:0]  blink_Mask;
  logic        blink_Tick;
  logic [3:0]  bcd_Out;
  logic        disp_On_Out;
  logic [3:0]  an_Out;
  logic [1:0]  digit_Idx;
  logic        frame_Done;

  int checks = 0;
  int errors = 0;

  // reference model: time since frame start, frame snapshot, blink phase
  bit          m_run;
  int          m_k;
  logic [15:0] m_snap;
  logic        m_phase;
  logic        m_vis;
  logic [3:0]  m_bcd;

  disp_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (S),
    .GUARD_CYCLES (G)
  ) dut (
    .clk         (clk),
    .reset_N     (reset_N),
    .enable      (enable),
    .digits_In   (digits_In),
    .blank_Mask  (blank_Mask),
    .blink_Mask  (blink_Mask),
    .blink_Tick  (blink_Tick),
    .bcd_Out     (bcd_Out),
    .disp_On_Out (disp_On_Out),
    .an_Out      (an_Out),
    .digit_Idx   (digit_Idx),
    .frame_Done  (frame_Done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_k     = 0;
    m_snap  = '0;
    m_phase = 1'b0;
    m_vis   = 1'b0;
    m_bcd   = '0;
  endtask

  task automatic model_edge();
    logic old_phase;
    int   slot;
    if (!reset_N) begin
      model_reset();
    end else begin
      old_phase = m_phase;
      m_phase   = m_phase ^ blink_Tick;
      if (!enable) begin
        m_run = 0;
        m_k   = 0;
      end else begin
        if (!m_run) begin
          m_run = 1;
          m_k   = 0;
        end else begin
          m_k++;
        end
        if (m_k % S == 0) begin
          slot = (m_k / S) % N;
          if (slot == 0) m_snap = digits_In;
          m_bcd = m_snap[4*slot +: 4];
          m_vis = !blank_Mask[slot] && !(blink_Mask[slot] && old_phase);
        end
      end
    end
  endtask

  task automatic check_outputs();
    int         slot;
    int         pos;
    logic [3:0] exp_an;
    logic       exp_on;
    logic       exp_fd;
    logic [1:0] exp_idx;
    exp_an  = 4'hF;
    exp_on  = 1'b0;
    exp_fd  = 1'b0;
    exp_idx = 2'd0;
    if (m_run) begin
      slot    = (m_k / S) % N;
      pos     = m_k % S;
      exp_idx = slot[1:0];
      exp_fd  = (slot == N-1) && (pos == S-1);
      if (pos >= G && m_vis) begin
        exp_an = ~(4'b0001 << slot);
        exp_on = 1'b1;
      end
      check_eq("bcd", bcd_Out, m_bcd);
    end
    check_eq("an", an_Out, exp_an);
    check_eq("disp_on", disp_On_Out, exp_on);
    check_eq("idx", digit_Idx, exp_idx);
    check_eq("frame_done", frame_Done, exp_fd);
    check_eq("an_onehot", ($countones(~an_Out) <= 1), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic async_reset();
    #2;
    reset_N = 1'b0;
    #1;
    check_eq("rst_an", an_Out, 4'hF);
    check_eq("rst_on", disp_On_Out, 0);
    check_eq("rst_idx", digit_Idx, 0);
    check_eq("rst_fd", frame_Done, 0);
    check_eq("rst_bcd", bcd_Out, 0);
    model_reset();
    @(negedge clk);
    reset_N = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    reset_N    = 1'b0;
    enable     = 1'b0;
    digits_In  = '0;
    blank_Mask = '0;
    blink_Mask = '0;
    blink_Tick = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_bcd", bcd_Out, 0);
    reset_N = 1'b1;

    // idle, enable low
    repeat (100) tick();

    // plain scan of 1234
    digits_In = 16'h1234;
    enable    = 1'b1;
    repeat (74) tick();

    // new digits mid-frame must wait for the next frame
    digits_In = 16'h5678;
    repeat (70) tick();

    // blank the leftmost digit
    blank_Mask = 4'b1000;
    repeat (40) tick();
    blank_Mask = 4'b0000;

    // blink digits 0-1 with a tick every 64 cycles
    blink_Mask = 4'b0011;
    for (int i = 0; i < 256; i++) begin
      blink_Tick = (i % 64 == 63);
      tick();
    end
    blink_Tick = 1'b0;
    blink_Mask = 4'b0000;

    // drop enable during DRIVE of slot 2, then re-enable
    waited = 0;
    while (!(m_run && ((m_k / S) % N == 2) && (m_k % S == 4)) && waited < 100) begin
      tick();
      waited++;
    end
    check_eq("wait_slot2", (waited < 100), 1);
    enable = 1'b0;
    tick();
    repeat (5) tick();
    digits_In = 16'h9ABC;
    enable    = 1'b1;
    repeat (40) tick();

    // asynchronous reset mid-slot
    repeat (3) tick();
    async_reset();
    repeat (40) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) digits_In = 16'($urandom);
      if ($urandom_range(99) < 2) begin
        blank_Mask = 4'($urandom);
        blink_Mask = 4'($urandom);
      end
      blink_Tick = ($urandom_range(99) < 4);
      if ($urandom_range(999) < 5) enable = ~enable;
      if ($urandom_range(999) < 2) async_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
